// File: rtl/video_pixel_pack_if.sv
// Video stream bundle for video_pixel_pack:
// raw pixel input side plus packed word output side.
interface video_pixel_pack_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int PACK_COUNT  = 4
);
   logic [PIXEL_WIDTH-1:0]            di_i;
   logic                              de_i;
   logic                              hs_i;
   logic                              vs_i;
   logic [PIXEL_WIDTH*PACK_COUNT-1:0] do_o;
   logic [PACK_COUNT-1:0]             be_o;
   logic                              de_o;
   logic                              eol_o;
   logic                              sof_o;
   logic                              hs_o;
   logic                              vs_o;

   modport master (
      output di_i, de_i, hs_i, vs_i,
      input  do_o, be_o, de_o, eol_o,
      input  sof_o, hs_o, vs_o
   );

   modport slave (
      input  di_i, de_i, hs_i, vs_i,
      output do_o, be_o, de_o, eol_o,
      output sof_o, hs_o, vs_o
   );
endinterface

// File: rtl/video_pixel_pack.sv
// Packs PACK_COUNT pixels per word with lane mask, eol and sof flags.
// Define VIDEO_PIXEL_PACK_ERR_EN to add the line-length check (err_o).
module video_pixel_pack #(
   parameter int PIXEL_WIDTH   = 8,
   parameter int PACK_COUNT    = 4,
   parameter int LINE_SIZE_MAX = 4096
) (
   input  logic clk,
   input  logic rst,
   video_pixel_pack_if.slave vid
`ifdef VIDEO_PIXEL_PACK_ERR_EN
   ,
   output logic err_o
`endif
);
   localparam int PW = PIXEL_WIDTH;
   localparam int PC = PACK_COUNT;
   localparam int CW = $clog2(PC + 1);

   if (PC < 2 || PC > 8 || LINE_SIZE_MAX < PC) begin : g_bad
      $error("video_pixel_pack: bad parameters");
   end

   logic [PC-1:0][PW-1:0] acc;
   logic [CW-1:0]         cnt;
   logic                  hs_q;
   logic                  vs_q;
   logic                  sof_pend;

   logic          accept;
   logic          hs_rise;
   logic          vs_fall;
   logic          vs_rise;
   logic          flush;
   logic          full;
   logic          emit;
   logic [PC-1:0] mask;

   always_comb begin
      accept  = vid.de_i & ~vid.hs_i & vid.vs_i;
      hs_rise = vid.hs_i & ~hs_q;
      vs_fall = ~vid.vs_i & vs_q;
      vs_rise = vid.vs_i & ~vs_q;
      flush   = hs_rise | vs_fall;
      full    = (cnt == CW'(PC));
      emit    = (accept & full) | (flush & (cnt != '0));
      mask    = '0;
      for (int k = 0; k < PC; k++) begin
         mask[k] = (CW'(k) < cnt);
      end
   end

   assign vid.hs_o = hs_q;
   assign vid.vs_o = vs_q;

   // A full word is held until the next pixel or a flush so that
   // eol is known exactly when it leaves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         cnt       <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b0;
         sof_pend  <= 1'b0;
         vid.do_o  <= '0;
         vid.be_o  <= '0;
         vid.de_o  <= 1'b0;
         vid.eol_o <= 1'b0;
         vid.sof_o <= 1'b0;
      end else begin
         hs_q      <= vid.hs_i;
         vs_q      <= vid.vs_i;
         vid.de_o  <= 1'b0;
         vid.eol_o <= 1'b0;
         vid.sof_o <= 1'b0;
         if (accept) begin
            if (full) begin
               vid.do_o  <= acc;
               vid.be_o  <= '1;
               vid.de_o  <= 1'b1;
               vid.sof_o <= sof_pend;
               acc       <= '0;
               acc[0]    <= vid.di_i;
               cnt       <= CW'(1);
            end else begin
               for (int k = 0; k < PC; k++) begin
                  if (cnt == CW'(k)) acc[k] <= vid.di_i;
               end
               cnt <= cnt + CW'(1);
            end
         end else if (flush && cnt != '0) begin
            vid.do_o  <= acc;
            vid.be_o  <= mask;
            vid.de_o  <= 1'b1;
            vid.eol_o <= 1'b1;
            vid.sof_o <= sof_pend;
            acc       <= '0;
            cnt       <= '0;
         end
         if (vs_rise) sof_pend <= 1'b1;
         else if (emit) sof_pend <= 1'b0;
      end
   end

`ifdef VIDEO_PIXEL_PACK_ERR_EN
   localparam int LW = $clog2(LINE_SIZE_MAX + 1);

   logic [LW-1:0] line_cnt;
   logic [LW-1:0] ref_len;
   logic          ref_vld;

   // Only non-empty lines take part in the comparison.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_cnt <= '0;
         ref_len  <= '0;
         ref_vld  <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (accept) begin
            if (line_cnt != LW'(LINE_SIZE_MAX))
               line_cnt <= line_cnt + LW'(1);
         end else if (flush) begin
            line_cnt <= '0;
            if (line_cnt != '0) begin
               ref_len <= line_cnt;
               ref_vld <= 1'b1;
               err_o   <= ref_vld && (ref_len != line_cnt);
            end
         end
         if (vs_rise) ref_vld <= 1'b0;
      end
   end
`endif
endmodule
